// File: rtl/boot_pkg.sv
// Shared widths, address step and state encoding for the boot loader.
package boot_pkg;

   localparam int ADDR_SIZE  = 8;
   localparam int WORD_SIZE  = 16;
   localparam int WORD_BYTES = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } boot_state_t;

endpackage

// File: rtl/boot_loader_if.sv
// CPU / RAM / ROM routing bus owned by the boot loader (master) and driven by the CPU side (slave).
interface boot_loader_if;
   import boot_pkg::*;

   logic                 cpu_wr_en;
   logic [ADDR_SIZE-1:0] cpu_addr;
   logic [WORD_SIZE-1:0] data_in;
   logic                 ram_wr_en;
   logic [ADDR_SIZE-1:0] ram_addr;
   logic                 rom_boot;
   logic                 cpu_stall;

   modport master (
      input  cpu_wr_en,
      input  cpu_addr,
      input  data_in,
      output ram_wr_en,
      output ram_addr,
      output rom_boot,
      output cpu_stall
   );

   modport slave (
      output cpu_wr_en,
      output cpu_addr,
      output data_in,
      input  ram_wr_en,
      input  ram_addr,
      input  rom_boot,
      input  cpu_stall
   );

endinterface

// File: rtl/boot_loader.sv
// Copies the ROM image into RAM one word per cycle, stalling the CPU until the copy
// and a one-cycle bus turnaround are complete.
module boot_loader
   import boot_pkg::*;
#(
   parameter int unsigned BASE_ADDR  = 0,
   parameter int unsigned LOAD_BYTES = 2**ADDR_SIZE,
   parameter bit          AUTO_BOOT  = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   boot_loader_if.master        bus,
   output logic                 busy,
   output logic                 done,
   output logic [WORD_SIZE-1:0] checksum
);

   // One extra counter bit so a full-range image reaches the terminal compare without wrapping.
   localparam int               CNT_W    = ADDR_SIZE + 1;
   localparam logic [CNT_W-1:0] BASE_CNT = CNT_W'(BASE_ADDR);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BASE_ADDR + LOAD_BYTES - WORD_BYTES);
   localparam logic [CNT_W-1:0] STEP     = CNT_W'(WORD_BYTES);

   boot_state_t      state;
   logic [CNT_W-1:0] load_addr;
   logic             auto_pending;
   logic             launch;

   assign launch = start | auto_pending;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         load_addr    <= BASE_CNT;
         checksum     <= '0;
         done         <= 1'b0;
         auto_pending <= AUTO_BOOT;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (launch) begin
                  state        <= LOAD;
                  load_addr    <= BASE_CNT;
                  checksum     <= '0;
                  done         <= 1'b0;
                  auto_pending <= 1'b0;
               end
            end
            LOAD: begin
               checksum  <= checksum + bus.data_in;
               load_addr <= load_addr + STEP;
               if (load_addr == LAST_CNT) begin
                  state <= FLUSH;
               end
            end
            FLUSH: begin
               state <= DONE;
               done  <= 1'b1;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // FLUSH releases the ROM drive without granting the CPU, leaving one dead bus cycle.
   always_comb begin
      bus.ram_addr  = bus.cpu_addr;
      bus.ram_wr_en = bus.cpu_wr_en;
      bus.rom_boot  = 1'b0;
      bus.cpu_stall = 1'b0;
      busy          = 1'b0;
      case (state)
         LOAD: begin
            bus.ram_addr  = load_addr[ADDR_SIZE-1:0];
            bus.ram_wr_en = 1'b1;
            bus.rom_boot  = 1'b1;
            bus.cpu_stall = 1'b1;
            busy          = 1'b1;
         end
         FLUSH: begin
            bus.ram_wr_en = 1'b0;
            bus.cpu_stall = 1'b1;
            busy          = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_boot_loader.sv
// Randomized scoreboard bench for boot_loader with behavioural ROM/RAM and a cycle-level reference model.
module tb_boot_loader;
   import boot_pkg::*;

   localparam int L_BYTES  = 8;
   localparam int N_WORDS  = L_BYTES / 2;
   localparam int BASE     = 0;
   localparam int MAX_WAIT = 40;

   typedef struct packed {
      logic [WORD_SIZE-1:0]   cks;
      logic [8*L_BYTES-1:0]   img;
   } load_exp_t;

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic                 start = 1'b0;
   logic                 start2 = 1'b0;
   logic                 busy, done, busy2, done2;
   logic [WORD_SIZE-1:0] checksum, checksum2;
   logic [WORD_SIZE-1:0] cpu_wdata = '0;
   logic [7:0]           rom [256];
   logic [7:0]           ram [256] = '{default: 8'h00};
   logic [ADDR_SIZE-1:0] hi_a, hi_a2;

   int n_checks = 0;
   int n_pass   = 0;

   load_exp_t            sb_q[$];
   logic [ADDR_SIZE-1:0] addr_q[$];
   int                   m_rem  = 0;
   bit                   m_auto = 1'b1;
   bit                   m_done = 1'b0;
   load_exp_t            m_e;
   load_exp_t            mon_e;
   logic [63:0]          act_img;
   logic [ADDR_SIZE-1:0] exp_addr;
   logic                 exp_wr;
   logic                 prev_done = 1'b0;

   boot_loader_if bif();
   boot_loader_if bif2();

   boot_loader #(.BASE_ADDR(BASE), .LOAD_BYTES(L_BYTES), .AUTO_BOOT(1'b1)) dut (
      .clk(clk), .rst(rst), .start(start), .bus(bif),
      .busy(busy), .done(done), .checksum(checksum)
   );

   boot_loader #(.BASE_ADDR(BASE), .LOAD_BYTES(L_BYTES), .AUTO_BOOT(1'b0)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .bus(bif2),
      .busy(busy2), .done(done2), .checksum(checksum2)
   );

   always #5 clk = ~clk;

   assign hi_a          = bif.ram_addr + 8'd1;
   assign bif.data_in   = bif.rom_boot ? {rom[hi_a], rom[bif.ram_addr]} : cpu_wdata;
   assign hi_a2         = bif2.ram_addr + 8'd1;
   assign bif2.data_in  = bif2.rom_boot ? {rom[hi_a2], rom[bif2.ram_addr]} : '0;
   assign bif2.cpu_wr_en = 1'b0;
   assign bif2.cpu_addr  = '0;

   always @(posedge clk) begin
      if (bif.ram_wr_en === 1'b1) begin
         ram[bif.ram_addr] <= bif.data_in[7:0];
         ram[hi_a]         <= bif.data_in[15:8];
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
   endtask

   // Reference: a load lasts N_WORDS write cycles plus one turnaround; expectations are queued at launch.
   initial forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
         m_rem = 0; m_auto = 1'b1; m_done = 1'b0;
         sb_q.delete(); addr_q.delete();
      end else if (m_rem > 0) begin
         m_rem--;
         if (m_rem == 0) m_done = 1'b1;
      end else if (start || m_auto) begin
         m_e.cks = '0;
         for (int k = 0; k < N_WORDS; k++) begin
            m_e.cks = m_e.cks + {rom[BASE + 2*k + 1], rom[BASE + 2*k]};
            addr_q.push_back(ADDR_SIZE'(BASE + 2*k));
         end
         for (int i = 0; i < L_BYTES; i++) m_e.img[8*i +: 8] = rom[BASE + i];
         sb_q.push_back(m_e);
         m_rem = N_WORDS + 1; m_done = 1'b0; m_auto = 1'b0;
      end
   end

   initial forever begin
      @(posedge clk);
      #1;
      if (m_rem > 1) exp_addr = (addr_q.size() > 0) ? addr_q.pop_front() : ~bif.ram_addr;
      else           exp_addr = bif.cpu_addr;
      exp_wr = (m_rem > 1) ? 1'b1 : ((m_rem == 1) ? 1'b0 : bif.cpu_wr_en);
      checkOutput("route",
                  {busy, bif.cpu_stall, bif.rom_boot, bif.ram_wr_en, bif.ram_addr, done},
                  {m_rem > 0, m_rem > 0, m_rem > 1, exp_wr, exp_addr, m_done});
      if (!rst) checkOutput("rst_checksum", checksum, '0);
      if (done && !prev_done && sb_q.size() > 0) begin
         mon_e = sb_q.pop_front();
         for (int i = 0; i < L_BYTES; i++) act_img[8*i +: 8] = ram[BASE + i];
         checkOutput("checksum", checksum, mon_e.cks);
         checkOutput("ram_image", act_img, mon_e.img);
      end
      prev_done = done;
   end

   task automatic set_rom_word(input int k, input logic [15:0] w);
      rom[BASE + 2*k]     = w[7:0];
      rom[BASE + 2*k + 1] = w[15:8];
   endtask

   task automatic applyStimulus();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int i = 0;
      while (!done && i < MAX_WAIT) begin
         @(negedge clk);
         i++;
      end
      checkOutput({name, "_done"}, done, 1'b1);
   endtask

   initial begin
      int n;
      int repulse_at;
      logic [15:0] sum2;
      bif.cpu_wr_en = 1'b0;
      bif.cpu_addr  = '0;
      for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
      set_rom_word(0, 16'h0102); set_rom_word(1, 16'h0304);
      set_rom_word(2, 16'h0506); set_rom_word(3, 16'h0708);

      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      bif.cpu_wr_en = 1'b1; bif.cpu_addr = 8'h10; cpu_wdata = 16'hBEEF;
      wait_done("auto_boot");
      checkOutput("cks_1014", checksum, 16'h1014);
      checkOutput("cpu_blocked", {ram[8'h11], ram[8'h10]}, 16'h0000);
      @(negedge clk);
      checkOutput("cpu_write_after_done", {ram[8'h11], ram[8'h10]}, 16'hBEEF);
      bif.cpu_wr_en = 1'b0;

      set_rom_word(0, 16'hFFFF); set_rom_word(1, 16'h0002);
      set_rom_word(2, 16'h0000); set_rom_word(3, 16'h0000);
      applyStimulus();
      wait_done("overflow");
      checkOutput("cks_overflow", checksum, 16'h0001);

      for (int it = 0; it < 6; it++) begin
         for (int i = 0; i < L_BYTES; i++) rom[BASE + i] = 8'($urandom);
         applyStimulus();
         repulse_at = $urandom_range(0, 5);
         n = 0;
         while (!done && n < MAX_WAIT) begin
            bif.cpu_wr_en = 1'($urandom);
            bif.cpu_addr  = ADDR_SIZE'($urandom);
            cpu_wdata     = 16'($urandom);
            start         = (n == repulse_at);
            @(negedge clk);
            n++;
         end
         start = 1'b0;
         bif.cpu_wr_en = 1'b0;
         checkOutput("random_load_done", done, 1'b1);
         @(negedge clk);
      end

      for (int i = 0; i < L_BYTES; i++) rom[BASE + i] = 8'($urandom);
      applyStimulus();
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("rst_done", done, 1'b0);
      checkOutput("rst_busy", busy, 1'b0);
      rst = 1'b1;
      wait_done("reset_restart");

      repeat (3) @(negedge clk);
      checkOutput("no_auto_busy2", busy2, 1'b0);
      checkOutput("no_auto_done2", done2, 1'b0);
      checkOutput("idle2_route", {bif2.rom_boot, bif2.cpu_stall, bif2.ram_wr_en, bif2.ram_addr}, '0);
      sum2 = '0;
      for (int k = 0; k < N_WORDS; k++) sum2 = sum2 + {rom[BASE + 2*k + 1], rom[BASE + 2*k]};
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      n = 0;
      while (busy2 && n < MAX_WAIT) begin
         n++;
         start2 = (n == 2);
         @(negedge clk);
      end
      start2 = 1'b0;
      checkOutput("load2_cycles", n, N_WORDS + 1);
      checkOutput("load2_done", done2, 1'b1);
      checkOutput("load2_checksum", checksum2, sum2);
      repeat (3) @(negedge clk);
      checkOutput("load2_no_requeue", busy2, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

endmodule
